// File: rtl/possf_sweep_ctrl_pkg.sv
// Shared types and defaults for the possf sweep controller.
package possf_pkg;

  localparam int N_IN_DEF   = 3;
  localparam int SETTLE_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic int tbl_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/possf_sweep_ctrl_if.sv
// Host + function-under-test signals for the sweep controller.
interface possf_sweep_ctrl_if
  import possf_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
);
  localparam int TW = tbl_width(N_IN);

  logic            start;
  logic            abort;
  logic [TW-1:0]   exp_tbl;
  logic            func_out;
  logic [N_IN-1:0] func_in;
  logic            busy;
  logic            done;
  logic [TW-1:0]   truth_tbl;
  logic            match;

  modport master (
    output start, abort, exp_tbl, func_out,
    input  func_in, busy, done, truth_tbl, match
  );

  modport slave (
    input  start, abort, exp_tbl, func_out,
    output func_in, busy, done, truth_tbl, match
  );
endinterface

// File: rtl/possf_sweep_ctrl_settle_timer.sv
// Loadable down-counter that holds at zero; zero flag is combinational.
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                  cnt_d = value;
    else if (dec && !zero)     cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/possf_sweep_ctrl.sv
// Sweeps the function block through all 2**N_IN vectors, builds its truth
// table and compares it against the expected mask latched at start.
module possf_sweep_ctrl
  import possf_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  possf_sweep_ctrl_if.slave  bus
);
  localparam int              TW       = tbl_width(N_IN);
  localparam int              CW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0]   SETTLE_V = CW'(SETTLE);
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN-1:0] func_in_q, func_in_d;
  logic [TW-1:0]   tbl_q, tbl_d;
  logic [TW-1:0]   exp_q, exp_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            match_q, match_d;
  logic            cnt_load, cnt_dec, cnt_zero;

  settle_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .value (SETTLE_V),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tbl_d    = tbl_q;
    exp_d    = exp_q;
    match_d  = match_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      ST_IDLE: if (bus.start && !bus.abort) begin
        idx_d    = '0;
        exp_d    = bus.exp_tbl;
        tbl_d    = '0;
        match_d  = 1'b0;
        cnt_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_zero) state_d = ST_SAMPLE;
        else          cnt_dec = 1'b1;
      end
      ST_SAMPLE: begin
        tbl_d[idx_q] = bus.func_out;
        if (idx_q == IDX_LAST) begin
          // compare against the final table so match is valid with done
          match_d = (tbl_d == exp_q);
          state_d = ST_DONE;
        end else begin
          idx_d    = idx_q + 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // abort drops any in-flight sample but keeps what was already captured
    if (bus.abort && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      tbl_d    = tbl_q;
      match_d  = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end

    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    func_in_d = (state_d == ST_WAIT || state_d == ST_SAMPLE) ? idx_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      func_in_q <= '0;
      tbl_q     <= '0;
      exp_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      func_in_q <= func_in_d;
      tbl_q     <= tbl_d;
      exp_q     <= exp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      match_q   <= match_d;
    end
  end

  assign bus.func_in   = func_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.truth_tbl = tbl_q;
  assign bus.match     = match_q;
endmodule

// File: tb/tb_possf_sweep_ctrl.sv
// Directed bench: two controllers (SETTLE=1 and SETTLE=0) driving y=(a|b)&d.
module tb_possf_sweep_ctrl;
  import possf_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_r = 1'b0;
  logic       abort_r = 1'b0;
  logic [7:0] exp_r = 8'h00;

  always #5 clk = ~clk;

  possf_sweep_ctrl_if #(.N_IN(3)) b1 ();
  possf_sweep_ctrl_if #(.N_IN(3)) b0 ();

  assign b1.start    = start_r;
  assign b1.abort    = abort_r;
  assign b1.exp_tbl  = exp_r;
  assign b1.func_out = (b1.func_in[2] | b1.func_in[1]) & b1.func_in[0];
  assign b0.start    = start_r;
  assign b0.abort    = abort_r;
  assign b0.exp_tbl  = exp_r;
  assign b0.func_out = (b0.func_in[2] | b0.func_in[1]) & b0.func_in[0];

  possf_sweep_ctrl #(.N_IN(3), .SETTLE(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  possf_sweep_ctrl #(.N_IN(3), .SETTLE(0)) u_s0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start a sweep and observe 40 cycles; cycle 1 is the one right after the start edge.
  task automatic sweep(input bit s0, input logic [7:0] et, input int restart_at,
                       output int done_at, output int n_done, output int n_busy,
                       output bit fi_bad);
    int per;
    logic [2:0] fi;
    per     = s0 ? 2 : 3;
    exp_r   = et;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    done_at = 0; n_done = 0; n_busy = 0; fi_bad = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      fi = s0 ? b0.func_in : b1.func_in;
      if (s0 ? b0.done : b1.done) begin
        n_done++;
        if (done_at == 0) done_at = c;
      end
      if (s0 ? b0.busy : b1.busy) n_busy++;
      if (c <= 8 * per && int'(fi) != (c - 1) / per) fi_bad = 1'b1;
      start_r = (c == restart_at);
      step();
    end
    start_r = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  done_at, n_done, n_busy;
    bit  fi_bad;

    // reset state
    rst_n = 1'b0;
    step(); step();
    chk("rst_busy",  b1.busy, 0);
    chk("rst_done",  b1.done, 0);
    chk("rst_fi",    b1.func_in, 0);
    chk("rst_tbl",   b1.truth_tbl, 0);
    chk("rst_match", b1.match, 0);
    rst_n = 1'b1;
    step();

    // 1: matching sweep
    sweep(1'b0, 8'hA8, 0, done_at, n_done, n_busy, fi_bad);
    chk("t1_done_at", done_at, 25);
    chk("t1_n_done",  n_done, 1);
    chk("t1_n_busy",  n_busy, 25);
    chk("t1_fi_seq",  fi_bad, 0);
    chk("t1_tbl",     b1.truth_tbl, 8'hA8);
    chk("t1_match",   b1.match, 1);
    chk("t1_busy",    b1.busy, 0);

    // 2: mismatching expectation
    sweep(1'b0, 8'hA9, 0, done_at, n_done, n_busy, fi_bad);
    chk("t2_done_at", done_at, 25);
    chk("t2_n_done",  n_done, 1);
    chk("t2_tbl",     b1.truth_tbl, 8'hA8);
    chk("t2_match",   b1.match, 0);

    // 3: abort in the WAIT of idx 4, after four vectors were sampled
    exp_r   = 8'hA8;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    repeat (12) step();
    chk("t3_pre_fi",   b1.func_in, 4);
    chk("t3_pre_busy", b1.busy, 1);
    abort_r = 1'b1;
    step();
    abort_r = 1'b0;
    chk("t3_busy", b1.busy, 0);
    chk("t3_fi",   b1.func_in, 0);
    chk("t3_done", b1.done, 0);
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (b1.done) n_done++;
      step();
    end
    chk("t3_no_done", n_done, 0);
    chk("t3_tbl",     b1.truth_tbl, 8'h08);
    chk("t3_match",   b1.match, 0);

    // start+abort together in IDLE: abort wins
    start_r = 1'b1;
    abort_r = 1'b1;
    step();
    start_r = 1'b0;
    abort_r = 1'b0;
    chk("sa_busy", b1.busy, 0);
    chk("sa_fi",   b1.func_in, 0);

    // 4: start pulsed again while busy
    sweep(1'b0, 8'hA8, 10, done_at, n_done, n_busy, fi_bad);
    chk("t4_done_at", done_at, 25);
    chk("t4_n_done",  n_done, 1);
    chk("t4_fi_seq",  fi_bad, 0);
    chk("t4_match",   b1.match, 1);

    // 5: one-cycle reset at cycle 20 (idx 0..5 sampled), with start+abort high
    exp_r   = 8'hA8;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    repeat (19) step();
    chk("t5_pre_tbl", b1.truth_tbl, 8'h28);
    rst_n   = 1'b0;
    start_r = 1'b1;
    abort_r = 1'b1;
    step();
    rst_n   = 1'b1;
    start_r = 1'b0;
    abort_r = 1'b0;
    chk("t5_busy",  b1.busy, 0);
    chk("t5_done",  b1.done, 0);
    chk("t5_fi",    b1.func_in, 0);
    chk("t5_tbl",   b1.truth_tbl, 0);
    chk("t5_match", b1.match, 0);
    sweep(1'b0, 8'hA8, 0, done_at, n_done, n_busy, fi_bad);
    chk("t5_done_at", done_at, 25);
    chk("t5_tbl2",    b1.truth_tbl, 8'hA8);
    chk("t5_match2",  b1.match, 1);

    // 6: SETTLE=0 instance
    sweep(1'b1, 8'hA8, 0, done_at, n_done, n_busy, fi_bad);
    chk("t6_done_at", done_at, 17);
    chk("t6_n_done",  n_done, 1);
    chk("t6_n_busy",  n_busy, 17);
    chk("t6_fi_seq",  fi_bad, 0);
    chk("t6_tbl",     b0.truth_tbl, 8'hA8);
    chk("t6_match",   b0.match, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
